// File: rtl/branch_resolve_if.sv
// Branch control bundle between the scheduler/ALU side and branch_resolve_unit.
// The slave modport is the tracker's view; the master modport is the scheduler/ALU view.
interface branch_resolve_if #(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = $clog2(NUM_WARPS)
);
  logic                 br_issue_valid;
  logic [NW_BITS-1:0]   br_issue_wid;
  logic [31:0]          br_issue_PC;
  logic                 br_issue_ready;

  logic                 branch_ctl_valid;
  logic                 branch_ctl_taken;
  logic [NW_BITS-1:0]   branch_ctl_wid;
  logic [31:0]          branch_ctl_dest;

  logic                 redirect_valid;
  logic [NW_BITS-1:0]   redirect_wid;
  logic [31:0]          redirect_PC;
  logic                 redirect_ready;

  logic [NUM_WARPS-1:0] wstall_mask;
  logic                 spurious_err;

  modport master (
    output br_issue_valid, br_issue_wid, br_issue_PC,
    input  br_issue_ready,
    output branch_ctl_valid, branch_ctl_taken, branch_ctl_wid, branch_ctl_dest,
    input  redirect_valid, redirect_wid, redirect_PC,
    output redirect_ready,
    input  wstall_mask, spurious_err
  );

  modport slave (
    input  br_issue_valid, br_issue_wid, br_issue_PC,
    output br_issue_ready,
    input  branch_ctl_valid, branch_ctl_taken, branch_ctl_wid, branch_ctl_dest,
    output redirect_valid, redirect_wid, redirect_PC,
    input  redirect_ready,
    output wstall_mask, spurious_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Per-warp branch stall tracker with a single round-robin redirect slot.
// Optional BRANCH_PERF_EN adds wrapping outcome counters perf_br_total / perf_br_taken.
module branch_resolve_unit #(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolve_if.slave   bus
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]       perf_br_total,
  output logic [31:0]       perf_br_taken
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PEND, ST_SLOT} warp_st_e;

  warp_st_e           st     [NUM_WARPS];
  logic [31:0]        br_pc  [NUM_WARPS];
  logic [31:0]        nxt_pc [NUM_WARPS];
  logic [NW_BITS-1:0] rr_ptr;

  logic               issue_acc;
  logic               res_ok;
  logic               hs;
  logic               load_en;
  logic               pick_found;
  logic [NW_BITS-1:0] pick_wid;
  logic [NW_BITS-1:0] idx;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign bus.br_issue_ready = (st[bus.br_issue_wid] == ST_IDLE);
  assign issue_acc          = bus.br_issue_valid && bus.br_issue_ready;
  assign res_ok             = bus.branch_ctl_valid && (st[bus.branch_ctl_wid] == ST_WAIT);
  assign hs                 = bus.redirect_valid && bus.redirect_ready;
  assign load_en            = !bus.redirect_valid || hs;

  // Round-robin pick over warps already PEND; descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_wid   = '0;
    idx        = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      idx = rr_ptr + NW_BITS'(i);
      if (st[idx] == ST_PEND) begin
        pick_found = 1'b1;
        pick_wid   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) st[w] <= ST_IDLE;
      rr_ptr             <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_wid   <= '0;
      bus.redirect_PC    <= '0;
      bus.wstall_mask    <= '0;
      bus.spurious_err   <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        case (st[w])
          ST_IDLE:
            if (issue_acc && bus.br_issue_wid == NW_BITS'(w)) begin
              st[w]              <= ST_WAIT;
              bus.wstall_mask[w] <= 1'b1;
            end
          ST_WAIT:
            if (res_ok && bus.branch_ctl_wid == NW_BITS'(w)) st[w] <= ST_PEND;
          ST_PEND:
            if (load_en && pick_found && pick_wid == NW_BITS'(w)) st[w] <= ST_SLOT;
          ST_SLOT:
            if (hs && bus.redirect_wid == NW_BITS'(w)) begin
              st[w]              <= ST_IDLE;
              bus.wstall_mask[w] <= 1'b0;
            end
          default: st[w] <= ST_IDLE;
        endcase
      end

      if (bus.branch_ctl_valid && !res_ok) bus.spurious_err <= 1'b1;

      // A handshaking slot refills in the same cycle for back-to-back redirects.
      if (load_en) begin
        bus.redirect_valid <= pick_found;
        if (pick_found) begin
          bus.redirect_wid <= pick_wid;
          bus.redirect_PC  <= nxt_pc[pick_wid];
          rr_ptr           <= pick_wid + NW_BITS'(1);
        end
      end
    end
  end

  // Issue needs IDLE and resolve needs WAIT, so one warp's PCs never see both writes at once.
  always_ff @(posedge clk) begin
    if (issue_acc) br_pc[bus.br_issue_wid] <= bus.br_issue_PC;
    if (res_ok)
      nxt_pc[bus.branch_ctl_wid] <= bus.branch_ctl_taken ? bus.branch_ctl_dest
                                                         : seq_pc(br_pc[bus.branch_ctl_wid]);
  end

`ifdef BRANCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_br_total <= '0;
      perf_br_taken <= '0;
    end else if (res_ok) begin
      perf_br_total <= perf_br_total + 32'd1;
      if (bus.branch_ctl_taken) perf_br_taken <= perf_br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Per-warp branch-resolution tracker on the scheduler side of the branch control interface. It stalls a warp when a branch is dispatched to the ALU and consumes the ALU's registered branch outcome (`valid`, `taken`, `wid`, `dest`). It then issues a single-slot, round-robin-arbitrated PC redirect to the warp scheduler and releases the stall once the redirect is accepted.

## Interface
- `NUM_WARPS`, default 4: number of warps; minimum 2, power of two.
- `NW_BITS`, default `$clog2(NUM_WARPS)`: warp-id width.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `br_issue_valid`  in  1  branch for warp `br_issue_wid` dispatched to the ALU this cycle.
- `br_issue_wid`  in  NW_BITS  issuing warp.
- `br_issue_PC`  in  32  PC of the branch instruction.
- `br_issue_ready`  out  1  combinational; 1 iff warp `br_issue_wid` is IDLE.
- `branch_ctl_valid`  in  1  resolved branch outcome; single-cycle pulse; no backpressure.
- `branch_ctl_taken`  in  1  1 = taken.
- `branch_ctl_wid`  in  NW_BITS  resolving warp.
- `branch_ctl_dest`  in  32  taken target.
- `redirect_valid`  out  1  registered; a redirect is held in the output slot.
- `redirect_wid`  out  NW_BITS  registered.
- `redirect_PC`  out  32  registered; next PC for the warp.
- `redirect_ready`  in  1  scheduler accepts the redirect.
- `wstall_mask`  out  NUM_WARPS  registered; bit w = 1 when warp w is not IDLE.
- `spurious_err`  out  1  sticky; set when an outcome arrives for a warp not in WAIT.

## Operation
Each warp has one state: IDLE, WAIT, PEND or SLOT.
- **Stored per warp:** the branch PC and the computed next PC.
- **IDLE → WAIT:** on `br_issue_valid && br_issue_ready`. The branch PC is latched.
- **WAIT → PEND:** on `branch_ctl_valid` with `branch_ctl_wid` = w.
  - Next PC = `branch_ctl_dest` if taken.
  - Otherwise next PC = branch PC + 4, computed 32-bit and wrapping (0xFFFFFFFC → 0x00000000).
- **Outcome for a warp not in WAIT:** ignored and `spurious_err` is set. It clears only on reset.
- **Output slot load:** the slot loads when it is empty, or when it is handshaking this cycle (`redirect_valid && redirect_ready`).
  - It loads one PEND warp, chosen round-robin starting at `rr_ptr`.
  - That warp moves PEND → SLOT and `rr_ptr` becomes the chosen warp + 1, modulo NUM_WARPS.
  - If no warp is PEND, the slot empties and `redirect_valid` drops.
- **SLOT → IDLE:** on `redirect_valid && redirect_ready`.
- **Output stability:** while `redirect_valid && !redirect_ready`, `redirect_wid` and `redirect_PC` hold stable.
- **Same warp issued and resolved in one cycle:** the resolve applies. The issue cannot be accepted because the warp is not IDLE.
- **Redirect handshake on warp w plus issue for w in the same cycle:** the issue is rejected (`br_issue_ready` = 0 because w is still SLOT). The issue can be accepted the following cycle.
- **Resolve on warp w plus a slot load in the same cycle:** w is not eligible for the load until the next cycle.
- **Reset:** asynchronous clear to the following values; mid-operation reset discards all pending redirects.
  - All warps IDLE, `rr_ptr` = 0.
  - `redirect_valid` = 0, `redirect_wid` = 0, `redirect_PC` = 0.
  - `wstall_mask` = 0, `spurious_err` = 0.

## Timing
- Issue accepted at edge t → `wstall_mask[w]` = 1 after edge t.
- Outcome sampled at edge t → warp PEND after t → `redirect_valid` after edge t+1 if the slot is free. Minimum latency is 2 edges.
- Redirect handshake at edge t → `wstall_mask[w]` = 0 after edge t. At the same edge the slot may reload, giving back-to-back redirects with 1/cycle throughput.
- `br_issue_ready` is the only combinational output. It depends on `br_issue_wid` and state only, not on `br_issue_valid`.

## Configuration
- `BRANCH_PERF_EN` defined: adds two ports.
  - `perf_br_total` (out, 32) and `perf_br_taken` (out, 32).
  - Registered, wrapping, reset to 0.
  - Both count accepted (non-spurious) outcomes; `perf_br_taken` counts only those with taken = 1.
- `BRANCH_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Single not-taken branch:** reset; issue w1 with PC 0x80000010; outcome w1, taken = 0, two cycles later.
  - Required: redirect w1, PC 0x80000014, 2 edges after the outcome.
  - Required: `wstall_mask` = 4'b0010 from issue until the handshake.
- **Taken with wrap:** issue w0 with PC 0xFFFFFFFC, outcome taken = 0 → redirect PC 0x00000000. Issue w0 with PC 0x100, taken = 1, dest 0x2000 → redirect PC 0x2000.
- **Arbitration under backpressure:** outcomes for w0–w3 in consecutive cycles, `redirect_ready` held 0 for 5 cycles then 1.
  - Required: w0 stays stable in the slot, then w1, w2, w3 follow on consecutive cycles.
  - Required: `rr_ptr` ends at 0.
- **Rejected issue:** issue w2 while w2 is WAIT → `br_issue_ready` = 0. Repeat the issue in the cycle of w2's redirect handshake → rejected; accepted one cycle later.
- **Spurious outcome:** outcome for IDLE w3 → no redirect, `spurious_err` = 1 and held until reset.
- **Reset mid-operation:** assert reset with w1 in SLOT and w2 in WAIT.
  - Required: all outputs 0 immediately.
  - With `BRANCH_PERF_EN`: counters read 0 after reset and 3/1 after outcomes taken, not-taken, not-taken.
